// File: rtl/jzjpcc_uart_pkg.sv
// Shared types and MMIO bit positions for the memory-mapped UART transmitter.
// ST_PARITY only exists when JZJPCC_UART_TX_PARITY_EN is defined.
package jzjpcc_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef JZJPCC_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int CMD_DATA_LSB  = 0;
    localparam int CMD_TOGGLE    = 8;
    localparam int CMD_OVF_CLR   = 9;

    localparam int STS_FULL      = 0;
    localparam int STS_EMPTY     = 1;
    localparam int STS_BUSY      = 2;
    localparam int STS_ACK       = 3;
    localparam int STS_OVF       = 4;
    localparam int STS_COUNT_LSB = 8;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/jzjpcc_uart_tx_fifo.sv
// Circular byte FIFO, 2^DEPTH_LOG2 entries; pop_dat shows the head combinationally.
// A push while full is accepted only if a pop happens on the same edge.
module jzjpcc_uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [7:0]            push_dat,
    input  logic                  pop,
    output logic [7:0]            pop_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  do_push, do_pop;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/jzjpcc_mmio_uart_tx.sv
// MMIO UART transmitter: toggle-handshake byte writes into a FIFO, 8N1 serialiser
// (8E1 when JZJPCC_UART_TX_PARITY_EN is defined). txd is registered and idles high.
module jzjpcc_mmio_uart_tx
    import jzjpcc_uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = 434,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] txCommand,
    output logic [31:0] txStatus,
    output logic        txd
);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLOCKS_PER_BIT - 1);

    tx_state_t                state_q, state_d;
    logic [15:0]              baud_q, baud_d;
    logic [2:0]               bit_idx_q, bit_idx_d;
    logic [7:0]               shift_q, shift_d;
    logic                     txd_q, txd_d;
    logic                     prev_toggle_q, prev_toggle_d;
    logic                     overflow_q, overflow_d;
    logic                     req_seen, baud_done;
    logic                     fifo_pop, fifo_full, fifo_empty;
    logic [7:0]               fifo_dat;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;
    logic                     cmd_unused;

    assign cmd_unused = ^txCommand[31:10];

    jzjpcc_uart_tx_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (req_seen),
        .push_dat (txCommand[CMD_DATA_LSB +: 8]),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        req_seen      = (txCommand[CMD_TOGGLE] != prev_toggle_q);
        prev_toggle_d = txCommand[CMD_TOGGLE];
        overflow_d    = overflow_q;
        if (txCommand[CMD_OVF_CLR]) overflow_d = 1'b0;
        // A drop on the same edge as a clear must stay visible.
        if (req_seen && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        baud_done = (baud_q == 16'd0);
        if (state_q != ST_IDLE && !baud_done) baud_d = baud_q - 16'd1;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dat;
                    baud_d   = BAUD_RELOAD;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef JZJPCC_UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef JZJPCC_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_done) begin
                    baud_d  = BAUD_RELOAD;
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (baud_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // txd is decoded from the next state so the line moves on the same edge as the FSM.
    always_comb begin
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[bit_idx_d];
`ifdef JZJPCC_UART_TX_PARITY_EN
            ST_PARITY: txd_d = even_parity(shift_d);
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            baud_q        <= 16'd0;
            bit_idx_q     <= 3'd0;
            shift_q       <= 8'd0;
            txd_q         <= 1'b1;
            prev_toggle_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            baud_q        <= baud_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            txd_q         <= txd_d;
            prev_toggle_q <= prev_toggle_d;
            overflow_q    <= overflow_d;
        end
    end

    assign txd = txd_q;

    always_comb begin
        txStatus                        = 32'd0;
        txStatus[STS_FULL]              = fifo_full;
        txStatus[STS_EMPTY]             = fifo_empty;
        txStatus[STS_BUSY]              = (state_q != ST_IDLE);
        txStatus[STS_ACK]               = prev_toggle_q;
        txStatus[STS_OVF]               = overflow_q;
        txStatus[STS_COUNT_LSB +: 8]    = 8'(fifo_count);
    end

endmodule

// File: tb/tb_jzjpcc_mmio_uart_tx.sv
// Bench for jzjpcc_mmio_uart_tx: random and directed bytes, line decoded from sampled txd.
// Frame length follows JZJPCC_UART_TX_PARITY_EN.
module tb_jzjpcc_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef JZJPCC_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] txCommand = 32'd0;
    logic [31:0] txStatus;
    logic        txd;

    jzjpcc_mmio_uart_tx #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
        .clock     (clock),
        .reset     (reset),
        .txCommand (txCommand),
        .txStatus  (txStatus),
        .txd       (txd)
    );

    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    bit         line_q[$];
    logic [7:0] got_q[$];
    int         gap_q[$];
    int         bad_frames;
    logic [7:0] exp_q[$];
    logic       tog = 1'b0;
    int         occ;
    logic       exp_ovf;
    logic [7:0] b;

    always @(posedge clock) begin
        #1;
        if (mon_en) line_q.push_back(txd);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the edge that sees the request.
    task automatic send(input logic [7:0] d, input logic clr);
        tog = ~tog;
        txCommand = {22'd0, clr, tog, d};
        @(negedge clock);
    endtask

    // Split the sampled line into frames; every sample of every bit must match the frame.
    task automatic decode_line();
        int i, n, idle;
        logic [7:0] db;
        logic eb;
        bit ok;
        got_q.delete();
        gap_q.delete();
        bad_frames = 0;
        i = 0; idle = 0; n = line_q.size();
        while (i < n) begin
            if (line_q[i] == 1'b1) begin
                idle++; i++;
            end else if (i + FRAME_BITS * CPB > n) begin
                bad_frames++; i = n;
            end else begin
                for (int d = 0; d < 8; d++) db[d] = line_q[i + (d + 1) * CPB + CPB / 2];
                ok = 1'b1;
                for (int k = 0; k < FRAME_BITS; k++) begin
                    if (k == 0)                    eb = 1'b0;
                    else if (k <= 8)               eb = db[k-1];
                    else if (k == FRAME_BITS - 1)  eb = 1'b1;
                    else                           eb = ^db;
                    for (int c = 0; c < CPB; c++)
                        if (line_q[i + k * CPB + c] != eb) ok = 1'b0;
                end
                if (!ok) bad_frames++;
                got_q.push_back(db);
                gap_q.push_back(idle);
                idle = 0;
                i += FRAME_BITS * CPB;
            end
        end
    endtask

    task automatic check_frames(input string tag);
        decode_line();
        check_eq({tag, "_nframes"}, got_q.size(), exp_q.size());
        check_eq({tag, "_badframes"}, bad_frames, 0);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_eq($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while (!(txStatus[2] == 1'b0 && txStatus[1] == 1'b1) && t < 3000) begin
            @(negedge clock);
            t++;
        end
        check_eq({tag, "_idle_in_time"}, t < 3000, 1);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_txd", txd, 1);
        check_eq("rst_status", txStatus, 32'h0000_0002);
        reset = 1'b0;
        @(negedge clock);

        // Single 0x55 frame: latency, ack and exact bit pattern.
        line_q.delete(); exp_q.delete(); mon_en = 1'b1;
        send(8'h55, 1'b0); exp_q.push_back(8'h55);
        check_eq("lat_ack", txStatus[3], tog);
        check_eq("lat_count", txStatus[15:8], 1);
        check_eq("lat_txd_k", txd, 1);
        @(negedge clock);
        check_eq("lat_txd_k1", txd, 0);
        check_eq("lat_busy", txStatus[2], 1);
        check_eq("lat_empty", txStatus[1], 1);
        wait_idle("b55");
        check_frames("b55");
        check_eq("b55_gap", gap_q.size() > 0 ? gap_q[0] : -1, 1);

        // Back-to-back bytes: one idle cycle between frames.
        line_q.delete(); exp_q.delete();
        send(8'hA5, 1'b0); exp_q.push_back(8'hA5);
        send(8'h3C, 1'b0); exp_q.push_back(8'h3C);
        wait_idle("b2b");
        check_frames("b2b");
        check_eq("b2b_gap", gap_q.size() > 1 ? gap_q[1] : -1, 1);

        // Overflow while the first frame is shifting, then clear semantics.
        line_q.delete(); exp_q.delete();
        send(8'h11, 1'b0); exp_q.push_back(8'h11);
        repeat (2) @(negedge clock);
        occ = 0; exp_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            send(b, 1'b0);
            if (occ < DEPTH) begin exp_q.push_back(b); occ++; end
            else exp_ovf = 1'b1;
        end
        check_eq("ovf_count", txStatus[15:8], occ);
        check_eq("ovf_full", txStatus[0], occ == DEPTH);
        check_eq("ovf_flag", txStatus[4], exp_ovf);
        send(8'hEE, 1'b1);
        check_eq("ovf_set_wins", txStatus[4], 1);
        txCommand = {22'd0, 1'b1, tog, 8'h00};
        @(negedge clock);
        check_eq("ovf_cleared", txStatus[4], 0);
        txCommand = {22'd0, 1'b0, tog, 8'h00};
        wait_idle("ovf");
        check_frames("ovf");

        // Random traffic with software that respects the full flag.
        line_q.delete(); exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            int t;
            b = (i == 0) ? 8'h07 : (i == 1) ? 8'h03 : 8'($urandom);
            t = 0;
            while (txStatus[0] && t < 500) begin @(negedge clock); t++; end
            check_eq("rnd_not_full_in_time", t < 500, 1);
            send(b, 1'b0); exp_q.push_back(b);
            repeat ($urandom_range(0, 60)) @(negedge clock);
        end
        wait_idle("rnd");
        check_frames("rnd");
        check_eq("rnd_ovf", txStatus[4], 0);

        // Reset 15 cycles into a frame with queued bytes and overflow pending.
        line_q.delete(); exp_q.delete();
        send(8'hC3, 1'b0);
        @(negedge clock);
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
        check_eq("rstmid_ovf_before", txStatus[4], 1);
        repeat (10) @(negedge clock);
        #2;
        reset = 1'b1; tog = 1'b0; txCommand = 32'd0;
        #1;
        check_eq("rstmid_txd", txd, 1);
        check_eq("rstmid_status", txStatus, 32'h0000_0002);
        @(negedge clock);
        reset = 1'b0;
        line_q.delete();
        repeat (300) @(negedge clock);
        check_frames("rstmid_after");
        check_eq("rstmid_status_after", txStatus, 32'h0000_0002);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jzjpcc_mmio_uart_tx.md
JZJPCC_MMIO_UART_TX -- requirements
Module: jzjpcc_mmio_uart_tx

Interface
REQ-001 Parameter CLOCKS_PER_BIT, default 434: clock cycles per serial bit; legal range 2 to 65535.
REQ-002 Parameter FIFO_DEPTH_LOG2, default 4: FIFO holds 2^FIFO_DEPTH_LOG2 bytes; legal range 1 to 7.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 txCommand  input  32  driven by one core mmioOutputs word; [7:0] data byte, [8] request toggle, [9] overflow clear (level), [31:10] ignored.
REQ-006 txStatus  output  32  drives one core mmioInputs word.
REQ-007 txStatus bit map: [0] full, [1] empty, [2] busy, [3] ack toggle, [4] overflow sticky, [15:8] FIFO count zero-extended, all other bits 0.
REQ-008 txd  output  1  serial line; idle high.

Function
REQ-009 Register prevToggle; a request SHALL be seen on any edge where txCommand[8] != prevToggle; prevToggle SHALL then take txCommand[8].
REQ-010 On a seen request with FIFO not full, txCommand[7:0] SHALL be written to the FIFO on that same edge.
REQ-011 On a seen request with FIFO full and no pop on that edge, the byte SHALL be dropped and overflow set; a pop on that edge means the push is accepted.
REQ-012 Ack toggle (txStatus[3]) SHALL equal prevToggle, so software polls ack == request before issuing the next byte.
REQ-013 overflow SHALL clear on any edge with txCommand[9]=1; a simultaneous set SHALL win.
REQ-014 FIFO: circular, read/write pointers wrap modulo depth; count range 0 to 2^FIFO_DEPTH_LOG2; simultaneous push and pop SHALL leave count unchanged.
REQ-015 FSM states IDLE, START, DATA, PARITY, STOP; txd registered.
REQ-016 IDLE: txd=1; if FIFO non-empty, pop into shift register, load baud counter with CLOCKS_PER_BIT-1, enter START.
REQ-017 START: txd=0 for CLOCKS_PER_BIT cycles, then DATA with bit index 0.
REQ-018 DATA: txd=shift[0], LSB first, CLOCKS_PER_BIT cycles per bit; after bit 7 go to PARITY (if compiled in), else STOP.
REQ-019 STOP: txd=1 for CLOCKS_PER_BIT cycles, then IDLE; with a byte waiting, the next START SHALL follow after exactly one IDLE cycle.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 Latency: a toggle change visible at edge k SHALL produce txd=0 after edge k+1 when the FIFO was empty and the FSM was IDLE.
REQ-022 Baud counter SHALL be a 16-bit down-counter; transition on reaching 0.

Reset
REQ-023 Reset SHALL set: prevToggle=0, FIFO pointers and count=0, overflow=0, FSM=IDLE, txd=1, baud counter=0, shift register=0.
REQ-024 Reset mid-frame SHALL abort the frame immediately, with txd high asynchronously and no queued bytes retained.

Configuration
REQ-025 With macro JZJPCC_UART_TX_PARITY_EN defined, PARITY state SHALL transmit even parity (XOR of the 8 data bits) for one bit time; frame = 11 bits.
REQ-026 Without JZJPCC_UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; frame = 10 bits.

Structure
REQ-027 Package jzjpcc_uart_pkg SHALL hold the FSM state enum and the txCommand/txStatus bit-position constants.
REQ-028 Sub-module jzjpcc_uart_tx_fifo SHALL implement the FIFO (push, pop, data, full, empty, count); the FSM and MMIO logic stay in the top.

Verification
REQ-029 With CLOCKS_PER_BIT=4 and parity off, toggle with byte 0x55 -> txd 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles (40 cycles total); start edge at k+1; ack equals request after edge k.
REQ-030 With the parity macro on and CLOCKS_PER_BIT=4, send 0x07 -> parity bit 1 and 44-cycle frame; send 0x03 -> parity bit 0.
REQ-031 With FIFO_DEPTH_LOG2=2, issue 6 requests while the first frame is shifting -> count reaches 4, full=1, overflow=1; exactly 5 frames appear on txd.
REQ-032 Raise command bit 9 on the same edge as an overflowing request -> overflow stays 1; a clear on a later edge gives 0.
REQ-033 Assert reset at cycle 15 of a frame -> txd=1 at once, status shows empty=1, busy=0, overflow=0, and no further frames.
REQ-034 Issue back-to-back bytes 0xA5 and 0x3C -> exactly one idle-high cycle between the STOP of 0xA5 and the START of 0x3C.
